// File: rtl/aes_block_loader.sv
// aes_block_loader: byte-serial input loader for the AES datapath.
// Collects bytes from the switches (one per synchronised load-button press), packs
// them MSB-first into a block and offers the block over a valid/ready handshake.
// Optional feature macro: AES_KEY_LOAD_EN adds a key-capture phase (key_data, key_bytes).
module aes_block_loader #(
    parameter int BLOCK_BYTES = 16,
    parameter int SYNC_STAGES = 2    // must be at least 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               sw_byte,
    input  logic                     load_btn,
    input  logic                     clear_btn,
    input  logic [1:0]               mode,
    output logic [8*BLOCK_BYTES-1:0] blk_data,
    output logic                     blk_valid,
    input  logic                     blk_ready,
    output logic [5:0]               byte_count,
    output logic                     busy,
    output logic                     ovf
`ifdef AES_KEY_LOAD_EN
    ,
    output logic [255:0]             key_data,
    output logic [5:0]               key_bytes
`endif
);

    localparam logic [5:0] DATA_BYTES = 6'(BLOCK_BYTES);
    localparam logic [5:0] LAST_DATA  = 6'(BLOCK_BYTES - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1
`ifdef AES_KEY_LOAD_EN
        ,
        KEY  = 2'd2
`endif
    } state_t;

    state_t                   state_q, state_d;
    logic [8*BLOCK_BYTES-1:0] data_q, data_d;
    logic [5:0]               count_q, count_d;
    logic                     ovf_q, ovf_d;
    logic [SYNC_STAGES-1:0]   load_sync_q, load_sync_d;
    logic [SYNC_STAGES-1:0]   clear_sync_q, clear_sync_d;
    logic                     load_prev_q, load_prev_d;
    logic                     clear_prev_q, clear_prev_d;
    logic                     load_ev, clear_ev;
`ifdef AES_KEY_LOAD_EN
    logic [255:0]             key_q, key_d;
    logic [255:0]             key_shift;
    logic [1:0]               mode_q, mode_d;
    logic [5:0]               key_last;
    logic [8:0]               key_pad;
`endif

    // Synchronise the raw buttons and turn each synced rising edge into a one-cycle event.
    always_comb begin
        load_sync_d  = {load_sync_q[SYNC_STAGES-2:0], load_btn};
        clear_sync_d = {clear_sync_q[SYNC_STAGES-2:0], clear_btn};
        load_prev_d  = load_sync_q[SYNC_STAGES-1];
        clear_prev_d = clear_sync_q[SYNC_STAGES-1];
        load_ev      = load_sync_q[SYNC_STAGES-1] & ~load_prev_q;
        clear_ev     = clear_sync_q[SYNC_STAGES-1] & ~clear_prev_q;
    end

`ifdef AES_KEY_LOAD_EN
    // Key length from the latched mode: last byte index of the frame and left-align shift.
    always_comb begin
        case (mode_q)
            2'b01:   begin key_last = DATA_BYTES + 6'd23; key_pad = 9'd64;  end
            2'b10:   begin key_last = DATA_BYTES + 6'd31; key_pad = 9'd0;   end
            default: begin key_last = DATA_BYTES + 6'd15; key_pad = 9'd128; end
        endcase
        key_shift = {key_q[247:0], sw_byte};
    end
`endif

    // Next-state logic: byte capture, handshake, overflow flag; clear overrides everything.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        ovf_d   = ovf_q;
`ifdef AES_KEY_LOAD_EN
        key_d   = key_q;
        mode_d  = mode_q;
`endif
        if (clear_ev) begin
            state_d = FILL;
            data_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
`ifdef AES_KEY_LOAD_EN
            key_d   = '0;
`endif
        end else begin
            case (state_q)
                FILL: begin
                    if (load_ev) begin
                        data_d  = {data_q[8*BLOCK_BYTES-9:0], sw_byte};
                        count_d = count_q + 6'd1;
`ifdef AES_KEY_LOAD_EN
                        if (count_q == '0) mode_d = mode;
                        if (count_q == LAST_DATA) state_d = KEY;
`else
                        if (count_q == LAST_DATA) state_d = HOLD;
`endif
                    end
                end
`ifdef AES_KEY_LOAD_EN
                KEY: begin
                    if (load_ev) begin
                        count_d = count_q + 6'd1;
                        if (count_q == key_last) begin
                            key_d   = key_shift << key_pad;
                            state_d = HOLD;
                        end else begin
                            key_d   = key_shift;
                        end
                    end
                end
`endif
                HOLD: begin
                    if (load_ev) ovf_d = 1'b1;
                    if (blk_ready) begin
                        state_d = FILL;
                        count_d = '0;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            data_q       <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            load_sync_q  <= '0;
            clear_sync_q <= '0;
            load_prev_q  <= 1'b0;
            clear_prev_q <= 1'b0;
`ifdef AES_KEY_LOAD_EN
            key_q        <= '0;
            mode_q       <= 2'b00;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, matching real hardware.
            state_q      <= state_d;
            data_q       <= data_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            load_sync_q  <= load_sync_d;
            clear_sync_q <= clear_sync_d;
            load_prev_q  <= load_prev_d;
            clear_prev_q <= clear_prev_d;
`ifdef AES_KEY_LOAD_EN
            key_q        <= key_d;
            mode_q       <= mode_d;
`endif
        end
    end

    assign blk_data   = data_q;
    assign blk_valid  = (state_q == HOLD);
    assign byte_count = count_q;
    assign busy       = (count_q != '0) && (state_q != HOLD);
    assign ovf        = ovf_q;
`ifdef AES_KEY_LOAD_EN
    assign key_data   = key_q;
    assign key_bytes  = (count_q > DATA_BYTES) ? (count_q - DATA_BYTES) : 6'd0;
`endif

endmodule

// File: tb/tb_aes_block_loader.sv
// tb_aes_block_loader: directed table, multi-cycle corner sequences and randomized
// button traffic checked against a press-level reference model.
module tb_aes_block_loader;

`ifdef AES_KEY_LOAD_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   sw_byte;
    logic         load_btn;
    logic         clear_btn;
    logic [1:0]   mode;
    logic [127:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic [5:0]   byte_count;
    logic         busy;
    logic         ovf;
`ifdef AES_KEY_LOAD_EN
    logic [255:0] key_data;
    logic [5:0]   key_bytes;
`endif

    aes_block_loader #(.BLOCK_BYTES(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_byte    (sw_byte),
        .load_btn   (load_btn),
        .clear_btn  (clear_btn),
        .mode       (mode),
        .blk_data   (blk_data),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .byte_count (byte_count),
        .busy       (busy),
        .ovf        (ovf)
`ifdef AES_KEY_LOAD_EN
        ,
        .key_data   (key_data),
        .key_bytes  (key_bytes)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, updated once per completed button action.
    logic [127:0] m_data;
    logic [255:0] m_key;
    int           m_count;
    bit           m_valid;
    bit           m_ovf;
    logic [1:0]   m_mode;

    typedef struct {
        logic [7:0] b;
        int         exp_count;
        bit         exp_valid;
        bit         exp_busy;
    } vec_t;
    vec_t vecs[16];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int key_len_of(input logic [1:0] m);
        case (m)
            2'b01:   return 24;
            2'b10:   return 32;
            default: return 16;
        endcase
    endfunction

    function automatic int frame_len();
`ifdef AES_KEY_LOAD_EN
        return 16 + key_len_of(m_mode);
`else
        return 16;
`endif
    endfunction

    task automatic model_reset();
        m_data = '0; m_key = '0; m_count = 0; m_valid = 0; m_ovf = 0; m_mode = 2'b00;
    endtask

    task automatic model_clear();
        m_data = '0; m_key = '0; m_count = 0; m_valid = 0; m_ovf = 0;
    endtask

    task automatic model_ready();
        if (m_valid) begin
            m_valid = 0;
            m_count = 0;
        end
    endtask

    task automatic model_press(input logic [7:0] b);
        if (m_valid) begin
            m_ovf = 1;
            return;
        end
        if (m_count == 0) m_mode = mode;
        if (m_count < 16) m_data = {m_data[119:0], b};
`ifdef AES_KEY_LOAD_EN
        else m_key = {m_key[247:0], b};
`endif
        m_count++;
        if (m_count == frame_len()) begin
            m_valid = 1;
`ifdef AES_KEY_LOAD_EN
            m_key = m_key << (8 * (32 - key_len_of(m_mode)));
`endif
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"},  blk_data,   m_data);
        check({tag, ".valid"}, blk_valid,  m_valid);
        check({tag, ".count"}, byte_count, m_count);
        check({tag, ".busy"},  busy,       (m_count != 0) && !m_valid);
        check({tag, ".ovf"},   ovf,        m_ovf);
`ifdef AES_KEY_LOAD_EN
        check({tag, ".key"},   key_data,   m_key);
        check({tag, ".kbytes"}, key_bytes, (m_count > 16) ? m_count - 16 : 0);
`endif
    endtask

    // One button press: held 4 clocks, released 4 clocks.
    task automatic press(input logic [7:0] b);
        sw_byte = b; load_btn = 1'b1; tick(4);
        load_btn = 1'b0; tick(4);
        model_press(b);
    endtask

    task automatic clear_press();
        clear_btn = 1'b1; tick(4);
        clear_btn = 1'b0; tick(4);
        model_clear();
    endtask

    task automatic handshake();
        blk_ready = 1'b1; tick(1);
        blk_ready = 1'b0; model_ready(); tick(1);
    endtask

    task automatic finish_frame();
        for (int k = 0; k < 64 && !m_valid; k++) press(8'($urandom_range(0, 255)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sw_byte = '0; load_btn = 0; clear_btn = 0; mode = 2'b00; blk_ready = 0;
        model_reset();
        tick(2);
        check_all("reset_held");
        reset = 1'b0; tick(2);
        check_all("reset_released");

        // Table: 16 presses 00,11,..,FF with per-press expectations.
        for (int i = 0; i < 16; i++) begin
            vecs[i].b         = 8'(i * 17);
            vecs[i].exp_count = i + 1;
            vecs[i].exp_valid = (i == 15) && !KEY_EN;
            vecs[i].exp_busy  = !vecs[i].exp_valid;
        end
        for (int i = 0; i < 16; i++) begin
            press(vecs[i].b);
            check("tbl.count", byte_count, vecs[i].exp_count);
            check("tbl.valid", blk_valid,  vecs[i].exp_valid);
            check("tbl.busy",  busy,       vecs[i].exp_busy);
        end
        check("tbl.block", blk_data, 128'h00112233445566778899aabbccddeeff);
        finish_frame();
        check_all("tbl.full");
        handshake();
        check_all("tbl.xfer");

        // A level held for 20 clocks yields exactly one capture.
        sw_byte = 8'h5A; load_btn = 1'b1; tick(20);
        load_btn = 1'b0; tick(4);
        model_press(8'h5A);
        check("hold20.count", byte_count, 1);
        check_all("hold20");

        // Capture latency on the 16th byte, then blk_ready low 10 clocks, then one-clock accept.
        clear_press();
        for (int i = 0; i < 15; i++) press(8'(i + 1));
        sw_byte = 8'hF0; load_btn = 1'b1; tick(2);
        check("lat.count_pre", byte_count, 15);
        check("lat.valid_pre", blk_valid, 1'b0);
        tick(1);
        check("lat.count_post", byte_count, 16);
        check("lat.valid_post", blk_valid, !KEY_EN);
        tick(1); load_btn = 1'b0; tick(4);
        model_press(8'hF0);
        check_all("lat");
        finish_frame();
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("stall.data", blk_data, m_data);
            check("stall.valid", blk_valid, 1'b1);
        end
        blk_ready = 1'b1; tick(1); blk_ready = 1'b0;
        model_ready();
        check("accept.valid", blk_valid, 1'b0);
        check("accept.count", byte_count, 0);
        check_all("accept");

        // Load during HOLD sets ovf and leaves the block alone; clear in HOLD withdraws valid.
        finish_frame();
        press(8'hEE);
        check("ovf.flag", ovf, 1'b1);
        check_all("ovf");
        clear_press();
        check("hold_clear.valid", blk_valid, 1'b0);
        check_all("hold_clear");

        // Clear and load events in the same cycle: clear wins, byte dropped.
        press(8'h01); press(8'h02); press(8'h03);
        sw_byte = 8'h77; load_btn = 1'b1; clear_btn = 1'b1; tick(4);
        load_btn = 1'b0; clear_btn = 1'b0; tick(4);
        model_clear();
        check("clr_load.count", byte_count, 0);
        check("clr_load.data", blk_data, 128'h0);
        check_all("clr_load");

        // Clear and blk_ready in HOLD in the same cycle: clear wins.
        finish_frame();
        clear_btn = 1'b1; tick(2);
        blk_ready = 1'b1; tick(1); blk_ready = 1'b0;
        tick(1); clear_btn = 1'b0; tick(4);
        model_clear();
        check_all("clr_ready");

        // Asynchronous reset after 7 bytes, then a clean 16-byte block.
        for (int i = 0; i < 7; i++) press(8'hC0 + 8'(i));
        @(posedge clk); #2 reset = 1'b1; #1;
        check("rst.data", blk_data, 128'h0);
        check("rst.count", byte_count, 0);
        check("rst.valid_busy_ovf", {blk_valid, busy, ovf}, 3'b000);
        model_reset();
        tick(1); reset = 1'b0; tick(1);
        for (int i = 0; i < 16; i++) press(8'hA0 + 8'(i));
        check("rst.block", blk_data, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);
        finish_frame();
        check_all("rst.frame");
        handshake();

`ifdef AES_KEY_LOAD_EN
        // 192-bit key frame: 16 data bytes plus key bytes 00..17.
        mode = 2'b01;
        for (int i = 0; i < 16; i++) press(8'(i));
        for (int k = 0; k < 24; k++) begin
            press(8'(k));
            if (k == 22) check("key.valid39", blk_valid, 1'b0);
        end
        check("key.valid40", blk_valid, 1'b1);
        check("key.count", byte_count, 40);
        check("key.kbytes", key_bytes, 24);
        check("key.data", key_data,
              {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
        check_all("key");
        handshake();
        mode = 2'b00;
`endif

        // Randomized traffic against the reference model.
        for (int n = 0; n < 200; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 55) press(8'($urandom_range(0, 255)));
            else if (r < 70) handshake();
            else if (r < 78) clear_press();
            else if (r < 92) mode = 2'($urandom_range(0, 3));
            else begin
                reset = 1'b1; tick(1); reset = 1'b0; tick(1);
                model_reset();
            end
            check_all("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
